pa_core_ifu: RTL
================

# pa_core_ifu

Instruction fetch unit for the MIPS core: owns the program counter, drives the instruction address into the ITCM, and registers the returned word into the IF/ID pipeline register for decode. The ITCM read is combinational, so a fetch issued from the PC register is captured at the next rising edge. The unit also handles stalls, branch redirects with one delay slot, exception redirects and flushes. On an unaligned fetch it parks until an exception redirect arrives.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, instruction width
- RESET_VECTOR, 32'hBFC0_0000, PC loaded by reset
- clk_i  in  1  core clock, rising edge
- rst_i  in  1  reset; one clock, synchronous, active-high
- stall_i  in  1  hold PC and IF/ID register
- flush_i  in  1  turn the IF/ID register into a bubble at the next edge
- jump_en_i  in  1  branch/jump taken (resolved in ID); keeps the delay slot
- jump_addr_i  in  ADDR_WIDTH  branch target
- expt_en_i  in  1  exception redirect; squashes the current fetch
- expt_addr_i  in  ADDR_WIDTH  exception handler address
- inst_addr_o  out  ADDR_WIDTH  fetch address to ITCM (equals PC register)
- inst_data_i  in  DATA_WIDTH  instruction word from ITCM, same cycle
- unalign_expt_i  in  1  ITCM flags inst_addr_o[1:0] != 0
- id_valid_o  out  1  IF/ID holds a real instruction
- id_pc_o  out  ADDR_WIDTH  PC of the IF/ID instruction
- id_inst_o  out  DATA_WIDTH  IF/ID instruction; 0 (NOP) when invalid or faulted
- id_unalign_o  out  1  IF/ID instruction faulted on fetch alignment

## Operation
- **State machine:** two states, RUN and PARK.
- **RUN behaviour:** every non-stalled edge captures {PC, inst_data_i, unalign_expt_i} into IF/ID and advances the PC.
- **Next-PC priority, evaluated each edge:**
  1. rst_i.
  2. expt_en_i selects expt_addr_i.
  3. stall_i holds the PC.
  4. jump_en_i selects jump_addr_i.
  5. In PARK, hold the PC.
  6. Otherwise PC + 4, with 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- **IF/ID update priority:**
  1. rst_i clears the register.
  2. expt_en_i or flush_i loads a bubble.
  3. stall_i holds the register.
  4. In PARK, load a bubble.
  5. Otherwise capture the fetch.
- **Bubble:** id_valid_o=0, id_inst_o=0, id_unalign_o=0. id_pc_o keeps its previous value.
- **Unaligned capture:** id_valid_o=1, id_unalign_o=1, id_inst_o=0, id_pc_o = faulting PC.
- **RUN→PARK:** on an edge that captures a fetch with unalign_expt_i=1 while expt_en_i=0 and stall_i=0. The PC is not advanced on that edge.
- **PARK→RUN:** only on expt_en_i. jump_en_i and flush_i do not leave PARK; jump_en_i in PARK still loads the PC.
- **Delay slot:** jump_en_i never squashes the instruction being fetched in the same cycle. That instruction is the delay slot and is captured normally.
- **stall_i with jump_en_i:** the jump is ignored. Decode re-presents it after the stall.
- **expt_en_i with stall_i:** expt_en_i wins on both the PC and IF/ID.
- **Reset:** from any state, including mid-stall or PARK, synchronously sets:
  - PC = RESET_VECTOR, state = RUN
  - id_valid_o=0, id_pc_o=0, id_inst_o=0, id_unalign_o=0

## Timing
- inst_addr_o is registered and equals the PC register. It changes only at clock edges.
- **Fetch latency:** the instruction at PC appears on id_* one edge after the PC is presented.
- **First instruction:** appears on id_* at the second edge after reset deasserts.
- **Redirect latency:** a redirect asserted in cycle N makes inst_addr_o = target in cycle N+1. The target instruction reaches id_* at edge N+2.
- **Throughput:** one instruction per cycle with no stall, flush or park.
- No combinational path from any input to any output. All outputs are flops.

## Test plan
- **Reset then free run:** rst_i for 2 cycles, then release.
  - inst_addr_o sequence: BFC0_0000, BFC0_0004, BFC0_0008.
  - id_valid_o rises one cycle after the first fetch, with id_pc_o=BFC0_0000.
- **Branch with delay slot:** jump_en_i=1 with jump_addr_i=BFC0_0100 while PC=BFC0_0008.
  - The BFC0_0008 instruction is still delivered to id_*.
  - Next inst_addr_o = BFC0_0100; no bubble.
- **Stall:** stall_i held 3 cycles at PC=BFC0_0010, with jump_en_i pulsed during the stall.
  - PC and all id_* are frozen.
  - The jump is ignored.
  - Sequence resumes at BFC0_0014.
- **Unaligned fetch:** jump to BFC0_0102.
  - id_unalign_o=1, id_inst_o=0, id_pc_o=BFC0_0102.
  - Afterwards id_valid_o=0 and inst_addr_o is held.
  - expt_en_i with expt_addr_i=BFC0_0380 resumes fetch at BFC0_0380.
- **Exception vs stall:** expt_en_i and stall_i both high.
  - IF/ID becomes a bubble.
  - Next inst_addr_o = BFC0_0380.
- **Reset mid-PARK:** assert rst_i while in PARK.
  - Next cycle inst_addr_o = BFC0_0000, all id_* outputs are 0, and normal fetch resumes.

Source files
------------

// File: rtl/pa_core_ifu.sv
// pa_core_ifu: instruction fetch unit for the MIPS core.
//
// This unit owns the program counter and drives it to the ITCM as the fetch
// address. The ITCM answers in the same cycle. The returned word is registered
// into the IF/ID pipeline register at the next rising edge.
//
// Redirects:
//   - Branch/jump: one delay slot is kept.
//   - Exception: squashes the current fetch.
// Flushes turn the IF/ID register into a bubble. After an unaligned fetch the
// unit parks until an exception redirect arrives.
//
// Ports:
//   clk_i           core clock, rising edge
//   rst_i           synchronous active-high reset
//   stall_i         hold PC and IF/ID
//   flush_i         IF/ID becomes a bubble at the next edge
//   jump_en_i       taken branch/jump from ID (delay slot preserved)
//   jump_addr_i     branch/jump target
//   expt_en_i       exception redirect (highest priority after reset)
//   expt_addr_i     exception handler address
//   inst_addr_o     fetch address to ITCM (the PC register itself)
//   inst_data_i     instruction word from ITCM, same cycle
//   unalign_expt_i  ITCM flags a misaligned fetch address
//   id_valid_o      IF/ID holds a real instruction
//   id_pc_o         PC of the IF/ID instruction
//   id_inst_o       IF/ID instruction word (0 when invalid or faulted)
//   id_unalign_o    IF/ID instruction faulted on alignment
module pa_core_ifu #(
    parameter int                      ADDR_WIDTH   = 32,
    parameter int                      DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  jump_en_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  expt_en_i,
    input  logic [ADDR_WIDTH-1:0] expt_addr_i,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    input  logic [DATA_WIDTH-1:0] inst_data_i,
    input  logic                  unalign_expt_i,
    output logic                  id_valid_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [DATA_WIDTH-1:0] id_inst_o,
    output logic                  id_unalign_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PARK = 1'b1
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic                  id_valid_reg;
    logic [ADDR_WIDTH-1:0] id_pc_reg;
    logic [DATA_WIDTH-1:0] id_inst_reg;
    logic                  id_unalign_reg;

    // A fetch is actually captured only in RUN with no redirect, stall or flush.
    // That is also the only edge on which an alignment fault can park the unit.
    logic capture;
    logic enter_park;

    assign capture    = (state_reg == ST_RUN) && !expt_en_i && !stall_i && !flush_i;
    assign enter_park = capture && unalign_expt_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_RUN;
            pc_reg         <= RESET_VECTOR;
            id_valid_reg   <= 1'b0;
            id_pc_reg      <= '0;
            id_inst_reg    <= '0;
            id_unalign_reg <= 1'b0;
        end else begin
            // ---------------- next PC ----------------
            if (expt_en_i) begin
                pc_reg <= expt_addr_i;
            end else if (stall_i) begin
                // A jump presented during a stall is dropped; decode re-presents it.
                pc_reg <= pc_reg;
            end else if (jump_en_i) begin
                // Jumps also load the PC while parked.
                pc_reg <= jump_addr_i;
            end else if (state_reg == ST_PARK || enter_park) begin
                pc_reg <= pc_reg;
            end else begin
                pc_reg <= pc_reg + ADDR_WIDTH'(4);
            end

            // ---------------- state ----------------
            if (expt_en_i) begin
                state_reg <= ST_RUN;
            end else if (enter_park) begin
                state_reg <= ST_PARK;
            end

            // ---------------- IF/ID register ----------------
            // A bubble keeps id_pc so decode still sees the last PC.
            if (expt_en_i || flush_i) begin
                id_valid_reg   <= 1'b0;
                id_inst_reg    <= '0;
                id_unalign_reg <= 1'b0;
            end else if (stall_i) begin
                id_valid_reg   <= id_valid_reg;
            end else if (state_reg == ST_PARK) begin
                id_valid_reg   <= 1'b0;
                id_inst_reg    <= '0;
                id_unalign_reg <= 1'b0;
            end else begin
                // A faulted fetch is delivered as a NOP tagged with the fault.
                id_valid_reg   <= 1'b1;
                id_pc_reg      <= pc_reg;
                id_inst_reg    <= unalign_expt_i ? '0 : inst_data_i;
                id_unalign_reg <= unalign_expt_i;
            end
        end
    end

    assign inst_addr_o  = pc_reg;
    assign id_valid_o   = id_valid_reg;
    assign id_pc_o      = id_pc_reg;
    assign id_inst_o    = id_inst_reg;
    assign id_unalign_o = id_unalign_reg;

endmodule
